// File: rtl/fib_job_queue.sv
// fib_job_queue: request FIFO and result buffer in front of the fibonacci core.
// Requests (n) arrive on a valid/ready stream and are queued in a DEPTH-entry FIFO.
// One job at a time is issued to the core with a single-cycle fib_start pulse.
// The core's ans is captured when it returns to done. It is then presented with its n
// on a valid/ready output stream.
// Optional feature macro: FIB_JOB_TAG_EN adds a 4-bit tag that travels with each job
// (in_tag -> out_tag).

module fib_job_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_n,
`ifdef FIB_JOB_TAG_EN
  input  logic [3:0]   in_tag,
  output logic [3:0]   out_tag,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [120:0] out_ans,
  output logic [4:0]   out_n,
  output logic         fib_start,
  output logic [4:0]   fib_n,
  input  logic         fib_done,
  input  logic [120:0] fib_ans,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
`ifdef FIB_JOB_TAG_EN
  localparam int EW = 9;
`else
  localparam int EW = 5;
`endif

  // state     | meaning
  // IDLE      | no job outstanding; pop the head when the core is idle
  // ISSUE     | fib_start asserted for this single cycle
  // WAIT_LOW  | waiting for the core to drop its idle-level done
  // WAIT_DONE | core computing; capture ans when done returns
  // HOLD      | result presented; wait for the consumer handshake
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  state_t         state_q, state_d;
  logic [4:0]     job_n_q, job_n_d;
  logic           fib_start_q, fib_start_d;
  logic           out_valid_q, out_valid_d;
  logic [120:0]   out_ans_q, out_ans_d;
  logic [4:0]     out_n_q, out_n_d;
`ifdef FIB_JOB_TAG_EN
  logic [3:0]     job_tag_q, job_tag_d;
  logic [3:0]     out_tag_q, out_tag_d;
`endif

  logic           push;
  logic           pop;
  logic [EW-1:0]  wr_entry;
  logic [EW-1:0]  head;

  assign in_ready = (count_q < CNT_FULL);
  assign push     = in_valid & in_ready;
  assign busy     = (state_q != IDLE) | (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

`ifdef FIB_JOB_TAG_EN
  assign wr_entry = {in_tag, in_n};
`else
  assign wr_entry = in_n;
`endif

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap at DEPTH naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Job sequencing: issue, wait out the core, capture and hold the result
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    job_n_d     = job_n_q;
    out_valid_d = out_valid_q;
    out_ans_d   = out_ans_q;
    out_n_d     = out_n_q;
`ifdef FIB_JOB_TAG_EN
    job_tag_d   = job_tag_q;
    out_tag_d   = out_tag_q;
`endif
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && fib_done) begin
          pop     = 1'b1;
          job_n_d = head[4:0];
`ifdef FIB_JOB_TAG_EN
          job_tag_d = head[8:5];
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // done is high while the core idles, so wait for it to fall first
        if (!fib_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (fib_done) begin
          out_ans_d   = fib_ans;
          out_n_d     = job_n_q;
`ifdef FIB_JOB_TAG_EN
          out_tag_d   = job_tag_q;
`endif
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // registered start: high exactly while the FSM sits in ISSUE
    fib_start_d = (state_d == ISSUE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      job_n_q     <= '0;
      fib_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_ans_q   <= '0;
      out_n_q     <= '0;
`ifdef FIB_JOB_TAG_EN
      job_tag_q   <= '0;
      out_tag_q   <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      job_n_q     <= job_n_d;
      fib_start_q <= fib_start_d;
      out_valid_q <= out_valid_d;
      out_ans_q   <= out_ans_d;
      out_n_q     <= out_n_d;
`ifdef FIB_JOB_TAG_EN
      job_tag_q   <= job_tag_d;
      out_tag_q   <= out_tag_d;
`endif
    end
  end

  assign fib_start = fib_start_q;
  assign fib_n     = job_n_q;
  assign out_valid = out_valid_q;
  assign out_ans   = out_ans_q;
  assign out_n     = out_n_q;
`ifdef FIB_JOB_TAG_EN
  assign out_tag   = out_tag_q;
`endif

endmodule

// File: tb/tb_fib_job_queue.sv
// Self-checking bench for fib_job_queue with a stub fibonacci core.
// The stub drops done one cycle after start, raises it 10 cycles later, and
// returns ans = n + 100. Accepted requests push their expected result to a
// scoreboard, and a monitor pops and compares each presented result.

module tb_fib_job_queue;

  typedef struct packed {
    logic [3:0]   tag;
    logic [4:0]   n;
    logic [120:0] ans;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_n;
  logic [3:0]   in_tag_r;
  logic         out_valid;
  logic         out_ready;
  logic [120:0] out_ans;
  logic [4:0]   out_n;
  logic         fib_start;
  logic [4:0]   fib_n;
  logic         fib_done;
  logic [120:0] fib_ans;
  logic         busy;
`ifdef FIB_JOB_TAG_EN
  logic [3:0]   out_tag;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   starts   = 0;
  bit   seen     = 1'b0;
  bit   prev_start = 1'b0;
  exp_t cur;
  exp_t sb[$];

  logic [4:0] stub_n;
  int         stub_cnt;

  always #5 clk = ~clk;

  fib_job_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
`ifdef FIB_JOB_TAG_EN
    .in_tag    (in_tag_r),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ans   (out_ans),
    .out_n     (out_n),
    .fib_start (fib_start),
    .fib_n     (fib_n),
    .fib_done  (fib_done),
    .fib_ans   (fib_ans),
    .busy      (busy)
  );

  // stub core
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fib_done <= 1'b1;
      stub_n   <= '0;
      stub_cnt <= 0;
    end else if (fib_start) begin
      fib_done <= 1'b0;
      stub_n   <= fib_n;
      stub_cnt <= 10;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) fib_done <= 1'b1;
    end
  end
  assign fib_ans = 121'(stub_n) + 121'd100;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: result scoreboard, start pulse and fib_n stability
  always @(negedge clk) begin
    if (!reset) begin
      if (fib_start) begin
        starts++;
        chk("start_core_idle", 128'(fib_done), 128'd1);
        chk("start_one_cycle", 128'(prev_start), 128'd0);
      end
      prev_start = fib_start;
      if (!fib_done) chk("fib_n_stable", 128'(fib_n), 128'(stub_n));
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 128'(out_valid), 128'd0);
          end else begin
            cur = sb.pop_front();
            chk("out_ans", 128'(out_ans), 128'(cur.ans));
            chk("out_n", 128'(out_n), 128'(cur.n));
`ifdef FIB_JOB_TAG_EN
            chk("out_tag", 128'(out_tag), 128'(cur.tag));
`endif
          end
          seen = 1'b1;
        end else begin
          chk("hold_ans_stable", 128'(out_ans), 128'(cur.ans));
          chk("hold_n_stable", 128'(out_n), 128'(cur.n));
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  always @(posedge reset) begin
    seen = 1'b0;
    prev_start = 1'b0;
  end

  // called and left at posedge+1
  task automatic push(input logic [4:0] n, input logic [3:0] tag, input int tries, output bit ok);
    bit   rdy;
    exp_t e;
    in_valid = 1'b1;
    in_n     = n;
    in_tag_r = tag;
    ok       = 1'b0;
    for (int i = 0; i < tries && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok    = 1'b1;
        e.tag = tag;
        e.n   = n;
        e.ans = 121'(n) + 121'd100;
        sb.push_back(e);
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  // returns at a negedge where out_valid is high, or records a timeout
  task automatic wait_ov(input int max, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      if (out_valid) hit = 1'b1;
    end
    chk(nm, 128'(hit), 128'd1);
  endtask

  task automatic drain(input int max, input string nm);
    bit idle = 1'b0;
    for (int i = 0; i < max && !idle; i++) begin
      @(negedge clk);
      if (!busy && !out_valid && sb.size() == 0) idle = 1'b1;
    end
    chk(nm, 128'(idle), 128'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw;
    int s0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_n      = '0;
    in_tag_r  = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_ans", 128'(out_ans), 128'd0);
    chk("rst_out_n", 128'(out_n), 128'd0);
    chk("rst_fib_start", 128'(fib_start), 128'd0);
    chk("rst_fib_n", 128'(fib_n), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
`ifdef FIB_JOB_TAG_EN
    chk("rst_out_tag", 128'(out_tag), 128'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // single job, consumer always ready
    out_ready = 1'b1;
    push(5'd5, 4'h0, 4, ok);
    chk("push5_accepted", 128'(ok), 128'd1);
    @(negedge clk);
    chk("no_start_before_pop", 128'(fib_start), 128'd0);
    chk("busy_after_push", 128'(busy), 128'd1);
    @(negedge clk);
    chk("start_after_pop", 128'(fib_start), 128'd1);
    chk("fib_n_issue", 128'(fib_n), 128'd5);
    wait_ov(40, "res5_timeout");
    @(negedge clk);
    chk("out_valid_one_cycle", 128'(out_valid), 128'd0);
    chk("idle_after_single", 128'(busy), 128'd0);

    // fill with consumer stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(5'd3, 4'h0, 1, ok);  chk("push3", 128'(ok), 128'd1);
    push(5'd7, 4'h0, 1, ok);  chk("push7", 128'(ok), 128'd1);
    push(5'd9, 4'h0, 1, ok);  chk("push9", 128'(ok), 128'd1);
    push(5'd12, 4'h0, 1, ok); chk("push12", 128'(ok), 128'd1);
    push(5'd15, 4'h0, 1, ok); chk("push5th_after_pop", 128'(ok), 128'd1);
    @(negedge clk);
    chk("in_ready_full", 128'(in_ready), 128'd0);
    push(5'd20, 4'h0, 3, ok);
    chk("push_full_ignored", 128'(ok), 128'd0);

    // accept 103, then hold 107 under backpressure
    wait_ov(60, "res3_timeout");
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_ov(60, "res7_timeout");
    #1 s0 = starts;
    repeat (20) begin
      @(negedge clk);
      chk("held_out_valid", 128'(out_valid), 128'd1);
    end
    #1;
    chk("no_start_while_held", 128'(starts), 128'(s0));
    chk("held_ans_107", 128'(out_ans), 128'd107);
    @(posedge clk); #1 out_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk); #1;
      if (starts != s0) saw = 1'b1;
    end
    chk("issue_after_release", 128'(saw), 128'd1);
    drain(200, "drain_order_timeout");

    // reset during WAIT_DONE with a second job queued
    @(posedge clk); #1;
    push(5'd8, 4'h0, 2, ok);  chk("push8", 128'(ok), 128'd1);
    push(5'd9, 4'h0, 2, ok);  chk("push9b", 128'(ok), 128'd1);
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      if (!fib_done) saw = 1'b1;
    end
    chk("core_went_busy", 128'(saw), 128'd1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_count", 128'(dut.count_q), 128'd0);
    chk("midrst_fib_start", 128'(fib_start), 128'd0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    s0 = starts;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    #1;
    chk("no_stale_result", 128'(saw), 128'd0);
    chk("no_start_after_rst", 128'(starts), 128'(s0));

`ifdef FIB_JOB_TAG_EN
    @(posedge clk); #1;
    push(5'd4, 4'hA, 2, ok); chk("push_tag_a", 128'(ok), 128'd1);
    push(5'd6, 4'h3, 2, ok); chk("push_tag_3", 128'(ok), 128'd1);
    drain(200, "drain_tag_timeout");
`endif

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_job_queue.md
# fib_job_queue

Request front end and result buffer for the `fibonacci` core. Accepts `n` values over a valid/ready stream into a small FIFO and drives the core's `start`/`n` inputs one job at a time. Captures the 121-bit `ans` when the core returns to done and presents it, paired with its `n`, on a valid/ready output stream. It sits between the system request source and the core on the input side, and between the core and the result consumer on the output side.

## Interface

Parameters:
- `DEPTH`, default 4: request FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: FIFO can accept (`count < DEPTH`).
- `in_n`, input, 5: Fibonacci index for the request.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `out_ans`, output, 121: captured core `ans`.
- `out_n`, output, 5: index that produced `out_ans`.
- `fib_start`, output, 1: to core `start`.
- `fib_n`, output, 5: to core `n`.
- `fib_done`, input, 1: from core `done` (high while the core is idle).
- `fib_ans`, input, 121: from core `ans`.
- `busy`, output, 1: FSM not in IDLE, or FIFO non-empty.

## Operation

- FIFO:
  - `DEPTH` entries with read/write pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
  - Push on `in_valid & in_ready`. Pop only on the IDLE→ISSUE transition.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - No bypass: an entry pushed this cycle is poppable at the earliest next cycle.
  - Full: `in_ready`=0 and pushes are ignored. Empty: no pop.
- FSM states are IDLE, ISSUE, WAIT_LOW, WAIT_DONE, HOLD:
  - **IDLE:** if count≠0 and `fib_done`=1, pop the head into `job_n` and go to ISSUE.
  - **ISSUE:** `fib_start`=1 for exactly this one cycle, then go to WAIT_LOW.
  - **WAIT_LOW:** wait for `fib_done`=0, then go to WAIT_DONE. This ignores the core's idle-level done.
  - **WAIT_DONE:** on `fib_done`=1, register `out_ans`←`fib_ans` and `out_n`←`job_n`, set `out_valid`, and go to HOLD.
  - **HOLD:** hold `out_valid`=1 with stable data until `out_ready`=1. On that handshake, clear `out_valid` and go to IDLE.
- `fib_n` is driven from the `job_n` register and is stable from ISSUE through HOLD. The core samples `n` after start, so it must never change mid-job.
- Only one job is outstanding. The next job is not issued until the previous result is accepted.

## Timing

- Reset values:
  - `out_valid`=0, `out_ans`=0, `out_n`=0.
  - `fib_start`=0, `fib_n`=0, `job_n`=0.
  - Pointers and count =0, FSM=IDLE, `busy`=0, `in_ready`=1.
- `in_ready` and `busy` are combinational from registered state. All other outputs are registered.
- Request accepted at edge E0 into an empty FIFO while IDLE with `fib_done`=1:
  - pop and move to ISSUE at E1;
  - `fib_start` high in the cycle after E1;
  - core samples `start` at E2.
- `out_valid` rises one cycle after the edge where WAIT_DONE samples `fib_done`=1.
- With `out_ready` held high, HOLD lasts 1 cycle and the next issue can start at the following edge.
- Reset mid-job: the FIFO is flushed, any held result is dropped, and the FSM returns to IDLE immediately. The core's synchronous reset must be driven from the same `reset` for at least one clock edge.

## Configuration

- `FIB_JOB_TAG_EN` defined:
  - adds ports `in_tag` (input, 4) and `out_tag` (output, 4);
  - each FIFO entry is 9 bits (`n` and tag);
  - the tag travels with the job and is registered into `out_tag` together with `out_ans`;
  - `out_tag` resets to 0.
- `FIB_JOB_TAG_EN` undefined: the tag ports are absent and FIFO entries are 5 bits.

## Test plan

The bench uses a stub core that drops done one cycle after `start`, raises it 10 cycles later, and returns `ans` = n+100.

- **Single job:** push n=5 with `out_ready`=1 → one `fib_start` pulse, `fib_n`=5 through completion, `out_ans`=105, `out_n`=5, `out_valid` high for one cycle.
- **Fill:** push 4 requests (3,7,9,12) with `out_ready`=0 → after the first pop, a 5th push is accepted. Then `in_ready`=0 once count hits 4, and further pushes are ignored.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after the result for n=7 appears → `out_ans`=107 stays stable and `fib_start` does not pulse. Releasing `out_ready` issues the next job.
- **Order:** push 3,7,9,12 → results appear in order as 103,107,109,112, each paired with the matching `out_n`.
- **Reset mid-job:** assert `reset` during WAIT_DONE → `out_valid`=0, `busy`=0, `in_ready`=1, count=0 with no clock edge required. No stale result appears afterwards.
- **Tags (with `FIB_JOB_TAG_EN`):** push n=4 tag=0xA and n=6 tag=0x3 → `out_tag` is 0xA then 0x3.
